// File: rtl/stream_comparator.sv
// Registered operand comparator with valid/ready handshakes, signed/unsigned mode,
// an equality tolerance band and saturating per-outcome event counters.
module stream_comparator #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_signed,
    input  logic [WIDTH-1:0] cfg_tol,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_equal,
    output logic             out_less,
    output logic             out_greater,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_equal,
    output logic [CNT_W-1:0] cnt_less,
    output logic [CNT_W-1:0] cnt_greater
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             out_valid_q,   out_valid_d;
    logic             out_equal_q,   out_equal_d;
    logic             out_less_q,    out_less_d;
    logic             out_greater_q, out_greater_d;
    logic [CNT_W-1:0] cnt_equal_q,   cnt_equal_d;
    logic [CNT_W-1:0] cnt_less_q,    cnt_less_d;
    logic [CNT_W-1:0] cnt_greater_q, cnt_greater_d;

    logic             accept;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   mag;
    logic [WIDTH:0]   tol_ext;
    logic             diff_neg;
    logic             res_equal;
    logic             res_less;
    logic             res_greater;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != CNT_MAX)) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    // Ready depends only on registered state and out_ready, never on in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // One extra bit makes the difference exact for both signed and unsigned operands.
    always_comb begin
        a_ext       = {cfg_signed & in_a[WIDTH-1], in_a};
        b_ext       = {cfg_signed & in_b[WIDTH-1], in_b};
        diff        = a_ext - b_ext;
        diff_neg    = diff[WIDTH];
        mag         = diff_neg ? -diff : diff;
        tol_ext     = {1'b0, cfg_tol};
        res_equal   = (mag <= tol_ext);
        res_less    = !res_equal && diff_neg;
        res_greater = !res_equal && !diff_neg;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_equal_d   = out_equal_q;
        out_less_d    = out_less_q;
        out_greater_d = out_greater_q;

        if (accept) begin
            out_valid_d   = 1'b1;
            out_equal_d   = res_equal;
            out_less_d    = res_less;
            out_greater_d = res_greater;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle accept, so that outcome is dropped from the counts.
    always_comb begin
        cnt_equal_d   = cnt_equal_q;
        cnt_less_d    = cnt_less_q;
        cnt_greater_d = cnt_greater_q;

        if (cnt_clear) begin
            cnt_equal_d   = '0;
            cnt_less_d    = '0;
            cnt_greater_d = '0;
        end else if (accept) begin
            cnt_equal_d   = sat_inc(cnt_equal_q,   res_equal);
            cnt_less_d    = sat_inc(cnt_less_q,    res_less);
            cnt_greater_d = sat_inc(cnt_greater_q, res_greater);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_equal_q   <= 1'b0;
            out_less_q    <= 1'b0;
            out_greater_q <= 1'b0;
            cnt_equal_q   <= '0;
            cnt_less_q    <= '0;
            cnt_greater_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_equal_q   <= out_equal_d;
            out_less_q    <= out_less_d;
            out_greater_q <= out_greater_d;
            cnt_equal_q   <= cnt_equal_d;
            cnt_less_q    <= cnt_less_d;
            cnt_greater_q <= cnt_greater_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_equal   = out_equal_q;
    assign out_less    = out_less_q;
    assign out_greater = out_greater_q;
    assign cnt_equal   = cnt_equal_q;
    assign cnt_less    = cnt_less_q;
    assign cnt_greater = cnt_greater_q;

endmodule

// File: tb/tb_stream_comparator.sv
// Directed bench for stream_comparator (WIDTH=8, CNT_W=4) with a cycle model and
// result scoreboard checked on every falling edge.
module tb_stream_comparator;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_signed;
    logic [W-1:0]  cfg_tol;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic          out_equal;
    logic          out_less;
    logic          out_greater;
    logic          cnt_clear;
    logic [CW-1:0] cnt_equal;
    logic [CW-1:0] cnt_less;
    logic [CW-1:0] cnt_greater;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: {equal, less, greater} results awaiting output handshake.
    logic [2:0] exp_q[$];
    logic [2:0] m_last = 3'b000;
    logic       m_valid = 1'b0;
    int         m_cnt_eq = 0;
    int         m_cnt_lt = 0;
    int         m_cnt_gt = 0;

    stream_comparator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_signed  (cfg_signed),
        .cfg_tol     (cfg_tol),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_equal   (out_equal),
        .out_less    (out_less),
        .out_greater (out_greater),
        .cnt_clear   (cnt_clear),
        .cnt_equal   (cnt_equal),
        .cnt_less    (cnt_less),
        .cnt_greater (cnt_greater)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sgn, input logic [W-1:0] tol);
        int ai, bi, d, m;
        ai = sgn ? int'($signed(a)) : int'(a);
        bi = sgn ? int'($signed(b)) : int'(b);
        d  = ai - bi;
        m  = (d < 0) ? -d : d;
        if (m <= int'(tol)) return 3'b100;
        if (d < 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_flags"}, 32'({out_equal, out_less, out_greater}), 32'(exp));
    endtask

    // Send one pair with out_ready=1, check its result, then idle one cycle.
    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] exp);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_flags(tag, exp);
        tick();
    endtask

    // Falling-edge monitor: compare DUT against the model, then advance the model.
    always @(negedge clk) begin
        logic take, acc;
        logic [2:0] res;
        if (rst) begin
            exp_q.delete();
            m_valid  = 1'b0;
            m_last   = 3'b000;
            m_cnt_eq = 0;
            m_cnt_lt = 0;
            m_cnt_gt = 0;
        end else begin
            check("mon_out_valid", 32'(out_valid), 32'(m_valid));
            check("mon_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            if (m_valid && exp_q.size() > 0)
                check("mon_flags_held", 32'({out_equal, out_less, out_greater}), 32'(exp_q[0]));
            else
                check("mon_flags_idle", 32'({out_equal, out_less, out_greater}), 32'(m_last));
            check("mon_cnt_equal", 32'(cnt_equal), 32'(m_cnt_eq));
            check("mon_cnt_less", 32'(cnt_less), 32'(m_cnt_lt));
            check("mon_cnt_greater", 32'(cnt_greater), 32'(m_cnt_gt));

            take = m_valid && out_ready;
            acc  = in_valid && (!m_valid || out_ready);
            res  = model(in_a, in_b, cfg_signed, cfg_tol);
            if (take && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(res);
                m_last = res;
            end
            m_valid = acc || (m_valid && !out_ready);
            if (cnt_clear) begin
                m_cnt_eq = 0;
                m_cnt_lt = 0;
                m_cnt_gt = 0;
            end else if (acc) begin
                if (res[2] && m_cnt_eq < 15) m_cnt_eq++;
                if (res[1] && m_cnt_lt < 15) m_cnt_lt++;
                if (res[0] && m_cnt_gt < 15) m_cnt_gt++;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        cfg_signed = 1'b0;
        cfg_tol    = '0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;
        cnt_clear  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flags", 32'({out_equal, out_less, out_greater}), 32'd0);
        check("rst_counters", 32'({cnt_equal, cnt_less, cnt_greater}), 32'd0);

        // Back-to-back unsigned exact compares.
        in_valid = 1'b1;
        in_a = 8'h05; in_b = 8'h05;
        tick();
        check_flags("b2b_eq", 3'b100);
        in_a = 8'h03; in_b = 8'h09;
        tick();
        check_flags("b2b_lt", 3'b010);
        in_a = 8'hF0; in_b = 8'h10;
        tick();
        check_flags("b2b_gt", 3'b001);
        in_valid = 1'b0;
        tick();
        check("b2b_drain_valid", 32'(out_valid), 32'd0);
        check("b2b_cnt_equal", 32'(cnt_equal), 32'd1);
        check("b2b_cnt_less", 32'(cnt_less), 32'd1);
        check("b2b_cnt_greater", 32'(cnt_greater), 32'd1);

        // Signed vs unsigned interpretation and extremes.
        cfg_signed = 1'b1;
        send("sgn_f0_10", 8'hF0, 8'h10, 3'b010);
        cfg_signed = 1'b0;
        send("uns_f0_10", 8'hF0, 8'h10, 3'b001);
        cfg_signed = 1'b1;
        send("sgn_80_7f", 8'h80, 8'h7F, 3'b010);
        send("sgn_7f_80", 8'h7F, 8'h80, 3'b001);
        cfg_signed = 1'b0;
        send("uns_80_7f", 8'h80, 8'h7F, 3'b001);

        // Tolerance band.
        cfg_tol = 8'd3;
        send("tol_10_13", 8'd10, 8'd13, 3'b100);
        send("tol_10_14", 8'd10, 8'd14, 3'b010);
        send("tol_14_10", 8'd14, 8'd10, 3'b001);
        cfg_signed = 1'b1;
        cfg_tol = 8'd255;
        send("tol_max_sgn", 8'h80, 8'h7F, 3'b100);
        cfg_signed = 1'b0;
        cfg_tol = 8'd3;

        // Config change while a result is held must not alter it.
        out_ready = 1'b0;
        in_a = 8'd10; in_b = 8'd13; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_tol = 8'd0;
        cfg_signed = 1'b1;
        tick();
        check_flags("hold_cfg_1", 3'b100);
        tick();
        check_flags("hold_cfg_2", 3'b100);
        out_ready = 1'b1;
        cfg_signed = 1'b0;
        tick();
        check("hold_cfg_taken", 32'(out_valid), 32'd0);

        // Backpressure: first pair held, second pair waits, then swap in one cycle.
        out_ready = 1'b0;
        in_a = 8'd1; in_b = 8'd2; in_valid = 1'b1;
        tick();
        check_flags("bp_first", 3'b010);
        in_a = 8'd9; in_b = 8'd2;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            tick();
            check_flags("bp_stable", 3'b010);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_flags("bp_second", 3'b001);
        tick();
        check("bp_drain_valid", 32'(out_valid), 32'd0);

        // Saturation and clear priority.
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clr_counters", 32'({cnt_equal, cnt_less, cnt_greater}), 32'd0);
        in_a = 8'd5; in_b = 8'd5; in_valid = 1'b1;
        repeat (20) tick();
        in_valid = 1'b0;
        tick();
        check("sat_cnt_equal", 32'(cnt_equal), 32'd15);
        check("sat_cnt_less", 32'(cnt_less), 32'd0);
        check("sat_cnt_greater", 32'(cnt_greater), 32'd0);
        in_a = 8'd1; in_b = 8'd2; in_valid = 1'b1; cnt_clear = 1'b1;
        tick();
        in_valid = 1'b0; cnt_clear = 1'b0;
        check_flags("clr_accept_result", 3'b010);
        check("clr_accept_counters", 32'({cnt_equal, cnt_less, cnt_greater}), 32'd0);
        tick();
        check("clr_accept_not_counted", 32'(cnt_less), 32'd0);

        // Reset while a result is held.
        out_ready = 1'b0;
        in_a = 8'd3; in_b = 8'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_flags("mid_held", 3'b100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_flags", 32'({out_equal, out_less, out_greater}), 32'd0);
        check("mid_rst_counters", 32'({cnt_equal, cnt_less, cnt_greater}), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send("post_rst", 8'd200, 8'd100, 3'b001);

        // Short random burst cross-checked by the monitor model.
        for (int i = 0; i < 60; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            cfg_signed = 1'($urandom_range(0, 1));
            cfg_tol    = W'($urandom_range(0, 8));
            in_a       = W'($urandom);
            in_b       = W'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_comparator.md
Name: stream_comparator

Overview:
Parametrised, registered successor to the combinational operand comparator. Accepts (a, b) operand pairs over a valid/ready stream, applies a run-time signed/unsigned mode and an equality tolerance band, and returns exactly one of equal/less/greater one cycle later over an output valid/ready stream. It also keeps saturating per-outcome event counters. These counters are readable by the SoC status logic and clearable by software control.

Parameters:
WIDTH, 32, operand width in bits (matches the soc_pkg data word).
CNT_W, 16, width of each outcome counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_signed  input  1  1 = two's-complement compare, 0 = unsigned
cfg_tol  input  WIDTH  tolerance, unsigned; |a-b| <= cfg_tol reports equal
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept a pair this cycle
in_a  input  WIDTH  operand a
in_b  input  WIDTH  operand b
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_equal  output  1  result: within tolerance
out_less  output  1  result: a < b beyond tolerance
out_greater  output  1  result: a > b beyond tolerance
cnt_clear  input  1  synchronous clear of all counters
cnt_equal  output  CNT_W  count of accepted equal outcomes
cnt_less  output  CNT_W  count of accepted less outcomes
cnt_greater  output  CNT_W  count of accepted greater outcomes

Behaviour:
- Reset: out_valid=0, out_equal=out_less=out_greater=0, all counters 0. in_ready=1 in the first cycle after reset. Reset mid-transfer discards the held result.
- Accept condition: in_valid && in_ready. in_ready = !out_valid || out_ready, so back-to-back throughput is 1 pair/cycle with no bubble. No combinational path from in_valid to in_ready.
- Latency: a pair accepted in cycle N produces a result with out_valid=1 in cycle N+1.
- Output hold: result register loads only on accept. While out_valid && !out_ready, all out_* stay stable.
- out_valid clears when the result is taken (out_valid && out_ready) without a new accept the same cycle. Taking a result and accepting a new pair in the same cycle keeps out_valid=1 and loads the new result.
- Flags hold their last value when out_valid=0. When out_valid=1, exactly one flag is high.
- Configuration: cfg_signed and cfg_tol are sampled only at accept. Changes while a result is held do not alter that result.
- Arithmetic:
  - Sign- or zero-extend a and b to WIDTH+1 bits according to cfg_signed.
  - diff = a_ext - b_ext in WIDTH+1 bits; mag = |diff| in WIDTH+1 bits. No overflow: the extension covers the full range.
  - equal if mag <= cfg_tol (zero-extended); else less if diff < 0; else greater.
  - cfg_tol=0 gives the exact comparator.
- Counters:
  - On each accept, the counter matching the computed outcome increments by 1 and saturates at 2^CNT_W-1.
  - Counters advance on input acceptance, not on output handshake.
  - cnt_clear has priority: a clear in the same cycle as an accept zeroes all counters, and that cycle's outcome is not counted.
  - Counter outputs are registered; an increment is visible the cycle after accept.

Test Plan:
- WIDTH=8, unsigned, tol=0: a=0x05, b=0x05 then a=0x03, b=0x09 then a=0xF0, b=0x10, out_ready=1 -> results equal, less, greater on consecutive cycles; cnt_equal=cnt_less=cnt_greater=1.
- Signed mode: a=0xF0 (-16), b=0x10 (16) -> out_less=1. Same pair unsigned -> out_greater=1. Extremes a=0x80, b=0x7F signed -> less, with no overflow.
- Tolerance: tol=3, a=10, b=13 -> equal; a=10, b=14 -> less; a=14, b=10 -> greater. Change tol to 0 while a result is held -> held flags unchanged.
- Backpressure: out_ready=0 with in_valid=1 for 4 cycles -> first pair accepted, in_ready=0 afterwards, out_* stable. Raise out_ready -> the next pair is accepted the same cycle the held result is taken; no pair lost or duplicated.
- Counter saturation/clear: CNT_W=4, 20 equal pairs -> cnt_equal=15. Assert cnt_clear on the same cycle as an accept -> all counters 0 the next cycle and that outcome not counted.
- Reset mid-operation: hold a valid result with out_ready=0, pulse rst -> out_valid=0, flags 0, counters 0, in_ready=1 in the following cycle.
